convb_ctrl: RTL and testbench
=============================

# convb_ctrl

Sequencer for the ConvB convolution datapath: the FIFO window, three parallel conv units, and per-unit weight/bias memories. After a one-cycle `start`, it walks every filter group and every input channel. For each pass it preloads the kernel from weight memory, streams the input feature map (IFM) into the line FIFO, and times the conv, accumulate, ReLU and output-write strobes. While idle it hands memory addressing back to the RISC-V port.

## Interface
Parameters:
- `IFM_SIZE`, 32, IFM width = height
- `IFM_DEPTH`, 3, input channels
- `KERNAL_SIZE`, 5, kernel edge
- `NUMBER_OF_FILTERS`, 6, total filters
- `NUMBER_OF_UNITS`, 3, parallel conv units; `GROUPS = NUMBER_OF_FILTERS/NUMBER_OF_UNITS`
- `PIPE_LATENCY`, 2, cycles from `conv_enable` to the datapath result being writable (≥1)
- Derived: `IFM_SIZE_NEXT = IFM_SIZE-KERNAL_SIZE+1`; `NUMBER_OF_WM = KERNAL_SIZE²`

Ports:
- `clk` in 1: the only clock
- `reset` in 1: synchronous, active-high
- `start` in 1: begin layer; sampled only in IDLE
- `stall` in 1: freeze; effective only with `CONVB_CTRL_STALL_EN`
- `busy` out 1: high from the cycle after `start` is sampled until DONE exits
- `done` out 1: one-cycle pulse in DONE
- `ifm_enable_read` out 1; `ifm_address_read` out `$clog2(IFM_SIZE²)`
- `fifo_enable`, `conv_enable`, `accu_enable`, `relu_enable` out 1
- `wm_addr_sel`, `wm_enable_read`, `wm_fifo_enable` out 1
- `wm_address_read_current` out `$clog2(NUMBER_OF_WM*IFM_DEPTH*(GROUPS+1))`
- `bm_addr_sel`, `bm_enable_read` out 1
- `bm_address_read_current` out `$clog2(NUMBER_OF_FILTERS)`
- `ofm_enable_read`, `ofm_enable_write` out 1
- `ofm_address_read`, `ofm_address_write` out `$clog2(IFM_SIZE_NEXT²)`

## Operation
- States: IDLE → LOAD_W → STREAM → DRAIN → (next pass: LOAD_W | DONE) → IDLE.
- Pass counters:
  - `g` is the filter group, 0..GROUPS-1, outer loop.
  - `d` is the channel, 0..IFM_DEPTH-1, inner loop.
  - Both counters clear on entry from IDLE.
- LOAD_W:
  - `wm_enable_read` is high for 25 cycles with address `(g*IFM_DEPTH+d)*NUMBER_OF_WM + k`, k = 0..24.
  - `wm_fifo_enable` follows, delayed 1 cycle, so the state lasts 26 cycles.
  - `bm_enable_read` is high in the first cycle, with `bm_address_read_current = g`.
- STREAM:
  - `ifm_enable_read` is high for `IFM_SIZE²` cycles, address 0..`IFM_SIZE²`-1.
  - `fifo_enable` is the same signal delayed 1 cycle.
- Window-valid rule:
  - Pushed pixel (r,c) is the one with index p = r*IFM_SIZE + c.
  - `conv_enable` is high in the cycle after its push iff r ≥ KERNAL_SIZE-1 and c ≥ KERNAL_SIZE-1.
- Output pipeline, with `oc` counting `conv_enable` pulses 0..`IFM_SIZE_NEXT²`-1:
  - When d > 0: `ofm_enable_read` = `conv_enable`, and `ofm_address_read` = `oc`.
  - When d > 0: `accu_enable` = `conv_enable` delayed `PIPE_LATENCY`-1 cycles.
  - When d = IFM_DEPTH-1: `relu_enable` is the same delayed signal.
  - `ofm_enable_write` = `conv_enable` delayed `PIPE_LATENCY` cycles; `ofm_address_write` carries the matching delayed `oc`.
- DRAIN lasts `PIPE_LATENCY`+1 cycles to flush the delay line. Then `d` increments; on wrap, `d` returns to 0 and `g` increments. After the last pass, go to DONE.
- DONE lasts 1 cycle.
- `wm_addr_sel` = `bm_addr_sel` = `busy`. In IDLE, RISC-V owns the weight and bias memories.
- All counters are binary and wrap exactly at their bounds. There is no carry into unused address bits.

## Timing
- Reset (synchronous) or IDLE: every output is 0, all counters are 0, and the state is IDLE.
- Reset asserted mid-pass aborts in the same edge, and all strobes drop the next cycle. No partial `done` is produced.
- `start` sampled at cycle 0 gives this schedule:
  - LOAD_W is cycles 1–26.
  - STREAM issues reads in cycles 27–1050.
  - DRAIN is cycles 1051–1053.
  - Each pass is 1053 cycles at default parameters.
- Six passes end at cycle 6318. `done` is high in cycle 6319; `busy` is low from cycle 6320.
- `start` while `busy` is ignored. `start` coincident with `reset` is ignored.
- Per pass: exactly `IFM_SIZE_NEXT²` = 784 `conv_enable` pulses and 784 `ofm_enable_write` pulses.
- The first `conv_enable` is at STREAM-start + 1 + 4*32+4 = cycle 160 of pass 0.

## Configuration
- `CONVB_CTRL_STALL_EN` defined:
  - While `stall` = 1, all state, counters and the delay line hold.
  - All one-cycle strobes (`*_enable*`, `done`) are forced to 0.
  - Addresses, `busy` and `*_addr_sel` hold.
  - Resume is seamless. `stall` in IDLE has no effect.
- `CONVB_CTRL_STALL_EN` undefined: `stall` is ignored, and no stall logic is synthesized.

## Test plan
- Reset, then pulse `start`:
  - `busy` rises at cycle 1.
  - `done` is a single pulse at cycle 6319.
  - 4704 `ofm_enable_write` pulses in total.
- Pass 0 address check:
  - `wm_address_read_current` is 0..24.
  - `bm_address_read_current` is 0.
  - The first `conv_enable` is at cycle 160.
  - `ofm_address_write` is 0..783 in order, the first at cycle 162.
- Pass 4 (g=1, d=1):
  - `wm_address_read_current` is 100..124.
  - `accu_enable` is high 784 times.
  - `relu_enable` is never high.
- Pulse `start` at cycle 500 while busy: no effect. Then assert `reset` at cycle 3000: all outputs are 0 at cycle 3001, no `done`, and a new `start` runs the full 6319-cycle sequence.
- With `CONVB_CTRL_STALL_EN`, hold `stall` for 10 cycles inside STREAM: `done` is delayed to cycle 6329, and the write count is still 4704 with no duplicates.
- `NUMBER_OF_FILTERS` = 3, `IFM_DEPTH` = 1: one pass; `relu_enable` has 784 pulses and `accu_enable` 0.

Source files
------------

// File: rtl/convb_ctrl.sv
// ConvB layer sequencer: weight preload, IFM streaming and conv/accu/relu/write strobe timing.
// Optional freeze input enabled by defining CONVB_CTRL_STALL_EN.
module convb_ctrl #(
    parameter int IFM_SIZE          = 32,
    parameter int IFM_DEPTH         = 3,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 6,
    parameter int NUMBER_OF_UNITS   = 3,
    parameter int PIPE_LATENCY      = 2,
    localparam int GROUPS        = NUMBER_OF_FILTERS / NUMBER_OF_UNITS,
    localparam int IFM_SIZE_NEXT = IFM_SIZE - KERNAL_SIZE + 1,
    localparam int NUMBER_OF_WM  = KERNAL_SIZE * KERNAL_SIZE,
    localparam int IA_W = $clog2(IFM_SIZE * IFM_SIZE),
    localparam int WA_W = $clog2(NUMBER_OF_WM * IFM_DEPTH * (GROUPS + 1)),
    localparam int BA_W = $clog2(NUMBER_OF_FILTERS),
    localparam int OA_W = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            ifm_enable_read,
    output logic [IA_W-1:0] ifm_address_read,
    output logic            fifo_enable,
    output logic            conv_enable,
    output logic            accu_enable,
    output logic            relu_enable,
    output logic            wm_addr_sel,
    output logic            wm_enable_read,
    output logic            wm_fifo_enable,
    output logic [WA_W-1:0] wm_address_read_current,
    output logic            bm_addr_sel,
    output logic            bm_enable_read,
    output logic [BA_W-1:0] bm_address_read_current,
    output logic            ofm_enable_read,
    output logic            ofm_enable_write,
    output logic [OA_W-1:0] ofm_address_read,
    output logic [OA_W-1:0] ofm_address_write
);
    localparam int NPIX = IFM_SIZE * IFM_SIZE;
    localparam int CW   = $clog2(NPIX + NUMBER_OF_WM + PIPE_LATENCY + 2);
    localparam int GW   = $clog2(GROUPS + 1);
    localparam int DW   = $clog2(IFM_DEPTH + 1);
    localparam int PW   = $clog2(IFM_SIZE + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t          r_state, w_n_state;
    logic [CW-1:0]   r_cnt, w_n_cnt;
    logic [GW-1:0]   r_g, w_n_g;
    logic [DW-1:0]   r_d, w_n_d;
    logic            r_busy, r_done;
    logic            r_wm_en, r_wm_fifo, r_bm_en, r_ifm_en, r_fifo;
    logic [WA_W-1:0] r_wm_addr, r_wm_ptr;
    logic [BA_W-1:0] r_bm_addr;
    logic [IA_W-1:0] r_ifm_addr;
    logic [PW-1:0]   r_row, r_col;
    logic [OA_W-1:0] r_oc_cnt;
    logic [PIPE_LATENCY:0] r_dv;
    logic [OA_W-1:0] r_doc [0:PIPE_LATENCY];
    logic            w_adv, w_live, w_win, w_wm_rd, w_bm_rd, w_ifm_rd;
    logic            w_last_d, w_last_g, w_d_nz, w_d_last;

    assign w_last_d = (r_d == DW'(IFM_DEPTH - 1));
    assign w_last_g = (r_g == GW'(GROUPS - 1));
    assign w_d_nz   = (r_d != '0);
    assign w_d_last = w_last_d;

    always_comb begin
        w_n_state = r_state;
        w_n_cnt   = r_cnt + 1'b1;
        w_n_g     = r_g;
        w_n_d     = r_d;
        case (r_state)
            S_IDLE: begin
                w_n_cnt = '0;
                if (start) begin
                    w_n_state = S_LOAD_W;
                    w_n_g     = '0;
                    w_n_d     = '0;
                end
            end
            S_LOAD_W: if (r_cnt == CW'(NUMBER_OF_WM)) begin
                w_n_state = S_STREAM;
                w_n_cnt   = '0;
            end
            S_STREAM: if (r_cnt == CW'(NPIX - 1)) begin
                w_n_state = S_DRAIN;
                w_n_cnt   = '0;
            end
            S_DRAIN: if (r_cnt == CW'(PIPE_LATENCY)) begin
                w_n_cnt = '0;
                if (w_last_d) begin
                    w_n_d = '0;
                    if (w_last_g) begin
                        w_n_state = S_DONE;
                    end else begin
                        w_n_g     = r_g + 1'b1;
                        w_n_state = S_LOAD_W;
                    end
                end else begin
                    w_n_d     = r_d + 1'b1;
                    w_n_state = S_LOAD_W;
                end
            end
            S_DONE: begin
                w_n_state = S_IDLE;
                w_n_cnt   = '0;
            end
            default: begin
                w_n_state = S_IDLE;
                w_n_cnt   = '0;
            end
        endcase
    end

    // Strobes are decoded from the upcoming position so a held position replays them after a freeze.
    assign w_wm_rd  = (w_n_state == S_LOAD_W) && (w_n_cnt < CW'(NUMBER_OF_WM));
    assign w_bm_rd  = (w_n_state == S_LOAD_W) && (w_n_cnt == '0);
    assign w_ifm_rd = (w_n_state == S_STREAM);
    assign w_win    = r_ifm_en && (r_row >= PW'(KERNAL_SIZE - 1)) && (r_col >= PW'(KERNAL_SIZE - 1));

`ifdef CONVB_CTRL_STALL_EN
    logic r_live;
    assign w_adv  = ~(stall && (r_state != S_IDLE));
    assign w_live = r_live;
    always_ff @(posedge clk) begin
        if (reset) r_live <= 1'b1;
        else       r_live <= w_adv;
    end
`else
    logic w_unused_stall;
    assign w_unused_stall = stall;
    assign w_adv  = 1'b1;
    assign w_live = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset || (w_adv && (w_n_state == S_IDLE))) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_g        <= '0;
            r_d        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wm_en    <= 1'b0;
            r_wm_fifo  <= 1'b0;
            r_bm_en    <= 1'b0;
            r_ifm_en   <= 1'b0;
            r_fifo     <= 1'b0;
            r_wm_addr  <= '0;
            r_wm_ptr   <= '0;
            r_bm_addr  <= '0;
            r_ifm_addr <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_oc_cnt   <= '0;
            r_dv       <= '0;
            for (int unsigned j = 0; j <= PIPE_LATENCY; j++) r_doc[j] <= '0;
        end else if (w_adv) begin
            r_state   <= w_n_state;
            r_cnt     <= w_n_cnt;
            r_g       <= w_n_g;
            r_d       <= w_n_d;
            r_busy    <= 1'b1;
            r_done    <= (w_n_state == S_DONE);
            r_wm_en   <= w_wm_rd;
            r_wm_fifo <= r_wm_en;
            r_bm_en   <= w_bm_rd;
            r_ifm_en  <= w_ifm_rd;
            r_fifo    <= r_ifm_en;
            if (w_wm_rd) begin
                r_wm_addr <= r_wm_ptr;
                r_wm_ptr  <= r_wm_ptr + 1'b1;
            end
            if (w_bm_rd) r_bm_addr <= BA_W'(w_n_g);
            if (w_ifm_rd) begin
                r_ifm_addr <= w_n_cnt[IA_W-1:0];
                if (w_n_cnt == '0) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (r_col == PW'(IFM_SIZE - 1)) begin
                    r_row <= r_row + 1'b1;
                    r_col <= '0;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_dv <= {r_dv[PIPE_LATENCY-1:0], w_win};
            if (w_win) begin
                r_doc[0] <= r_oc_cnt;
                r_oc_cnt <= r_oc_cnt + 1'b1;
            end
            if (w_n_state == S_LOAD_W) r_oc_cnt <= '0;
            for (int unsigned j = 1; j <= PIPE_LATENCY; j++) r_doc[j] <= r_doc[j-1];
        end
    end

    assign busy                    = r_busy;
    assign wm_addr_sel             = r_busy;
    assign bm_addr_sel             = r_busy;
    assign done                    = r_done & w_live;
    assign wm_enable_read          = r_wm_en & w_live;
    assign wm_fifo_enable          = r_wm_fifo & w_live;
    assign wm_address_read_current = r_wm_addr;
    assign bm_enable_read          = r_bm_en & w_live;
    assign bm_address_read_current = r_bm_addr;
    assign ifm_enable_read         = r_ifm_en & w_live;
    assign ifm_address_read        = r_ifm_addr;
    assign fifo_enable             = r_fifo & w_live;
    assign conv_enable             = r_dv[0] & w_live;
    assign ofm_enable_read         = r_dv[0] & w_d_nz & w_live;
    assign ofm_address_read        = r_doc[0];
    assign accu_enable             = r_dv[PIPE_LATENCY-1] & w_d_nz & w_live;
    assign relu_enable             = r_dv[PIPE_LATENCY-1] & w_d_last & w_live;
    assign ofm_enable_write        = r_dv[PIPE_LATENCY] & w_live;
    assign ofm_address_write       = r_doc[PIPE_LATENCY];
endmodule

// File: tb/tb_convb_ctrl.sv
// Self-checking bench for convb_ctrl: closed-form per-cycle schedule model, random start/stall pokes.
// Stall expectations follow CONVB_CTRL_STALL_EN when it is defined.
module tb_convb_ctrl;
    localparam int IFM = 32, D = 3, K = 5, NF = 6, NU = 3, PL = 2;
    localparam int G = NF / NU, ON = IFM - K + 1, WM = K * K, NPIX = IFM * IFM;
    localparam int PASS_LEN = WM + 1 + NPIX + PL + 1;
    localparam int NPASS = G * D;
    localparam int LAST = NPASS * PASS_LEN;
`ifdef CONVB_CTRL_STALL_EN
    localparam bit STALL_EN = 1'b1;
    localparam int NST = 10;
`else
    localparam bit STALL_EN = 1'b0;
    localparam int NST = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, stall = 1'b0, start2 = 1'b0;
    always #5 clk = ~clk;

    logic busy, done, ifm_en, fifo_en, conv_en, accu_en, relu_en;
    logic wm_sel, wm_en, wm_fifo, bm_sel, bm_en, ofm_rd, ofm_wr;
    logic [9:0] ifm_addr, ofm_raddr, ofm_waddr;
    logic [7:0] wm_addr;
    logic [2:0] bm_addr;

    convb_ctrl #(.IFM_SIZE(IFM), .IFM_DEPTH(D), .KERNAL_SIZE(K), .NUMBER_OF_FILTERS(NF),
                 .NUMBER_OF_UNITS(NU), .PIPE_LATENCY(PL)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .busy(busy), .done(done),
        .ifm_enable_read(ifm_en), .ifm_address_read(ifm_addr), .fifo_enable(fifo_en),
        .conv_enable(conv_en), .accu_enable(accu_en), .relu_enable(relu_en),
        .wm_addr_sel(wm_sel), .wm_enable_read(wm_en), .wm_fifo_enable(wm_fifo),
        .wm_address_read_current(wm_addr), .bm_addr_sel(bm_sel), .bm_enable_read(bm_en),
        .bm_address_read_current(bm_addr), .ofm_enable_read(ofm_rd), .ofm_enable_write(ofm_wr),
        .ofm_address_read(ofm_raddr), .ofm_address_write(ofm_waddr));

    // Single-group, single-channel variant: one pass, every result goes through ReLU.
    logic busy2, done2, ifm_en2, fifo_en2, conv_en2, accu_en2, relu_en2;
    logic wm_sel2, wm_en2, wm_fifo2, bm_sel2, bm_en2, ofm_rd2, ofm_wr2;
    logic [9:0] ifm_addr2, ofm_raddr2, ofm_waddr2;
    logic [5:0] wm_addr2;
    logic [1:0] bm_addr2;

    convb_ctrl #(.IFM_SIZE(IFM), .IFM_DEPTH(1), .KERNAL_SIZE(K), .NUMBER_OF_FILTERS(3),
                 .NUMBER_OF_UNITS(3), .PIPE_LATENCY(PL)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stall(1'b0), .busy(busy2), .done(done2),
        .ifm_enable_read(ifm_en2), .ifm_address_read(ifm_addr2), .fifo_enable(fifo_en2),
        .conv_enable(conv_en2), .accu_enable(accu_en2), .relu_enable(relu_en2),
        .wm_addr_sel(wm_sel2), .wm_enable_read(wm_en2), .wm_fifo_enable(wm_fifo2),
        .wm_address_read_current(wm_addr2), .bm_addr_sel(bm_sel2), .bm_enable_read(bm_en2),
        .bm_address_read_current(bm_addr2), .ofm_enable_read(ofm_rd2), .ofm_enable_write(ofm_wr2),
        .ofm_address_read(ofm_raddr2), .ofm_address_write(ofm_waddr2));

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    int m_s = 0;
    bit m_live = 1'b1;
    int n_wr, n_done, done_cyc, n_relu2, n_accu2, n_wr2, done2_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Output index of the window completed at local pass cycle q, or -1.
    function automatic int conv_oc(input int q);
        int p;
        p = q - (WM + 2);
        if (p < 0 || p >= NPIX) return -1;
        if (p / IFM >= K - 1 && p % IFM >= K - 1) return (p / IFM - (K - 1)) * ON + (p % IFM - (K - 1));
        return -1;
    endfunction

    task automatic step(input bit rst, input bit st, input bit sl, input bit st2);
        logic [13:0] obs, expv;
        int pass, q, g, d, oc0, oca, ocw;
        bit act;
        @(negedge clk);
        obs = {busy, done, wm_sel, bm_sel, wm_en, wm_fifo, bm_en, ifm_en, fifo_en,
               conv_en, ofm_rd, accu_en, relu_en, ofm_wr};
        expv = '0;
        act = (m_s > 0) && (m_s <= LAST) && m_live;
        pass = 0; q = 0; g = 0; d = 0; oc0 = -1; oca = -1; ocw = -1;
        if (m_s > 0) begin
            expv[13] = 1'b1;
            expv[11] = 1'b1;
            expv[10] = 1'b1;
        end
        if (m_s == LAST + 1 && m_live) expv[12] = 1'b1;
        if (act) begin
            pass = (m_s - 1) / PASS_LEN;
            q    = (m_s - 1) % PASS_LEN;
            g    = pass / D;
            d    = pass % D;
            oc0  = conv_oc(q);
            oca  = conv_oc(q - (PL - 1));
            ocw  = conv_oc(q - PL);
            expv[9] = (q < WM);
            expv[8] = (q >= 1 && q <= WM);
            expv[7] = (q == 0);
            expv[6] = (q >= WM + 1 && q < WM + 1 + NPIX);
            expv[5] = (q >= WM + 2 && q < WM + 2 + NPIX);
            expv[4] = (oc0 >= 0);
            expv[3] = (oc0 >= 0 && d > 0);
            expv[2] = (oca >= 0 && d > 0);
            expv[1] = (oca >= 0 && d == D - 1);
            expv[0] = (ocw >= 0);
        end
        check("strobes", obs, expv);
        if (expv[9]) check("wm_addr", wm_addr, pass * WM + q);
        if (expv[7]) check("bm_addr", bm_addr, g);
        if (expv[6]) check("ifm_addr", ifm_addr, q - (WM + 1));
        if (expv[3]) check("ofm_raddr", ofm_raddr, oc0);
        if (expv[0]) check("ofm_waddr", ofm_waddr, ocw);
        if (m_s == 0) check("idle_addr", {ifm_addr, wm_addr, bm_addr, ofm_raddr, ofm_waddr}, 0);
        if (ofm_wr) n_wr++;
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (relu_en2) n_relu2++;
        if (accu_en2) n_accu2++;
        if (ofm_wr2) n_wr2++;
        if (done2 && done2_cyc < 0) done2_cyc = cyc;
        reset = rst;
        start = st;
        stall = sl;
        start2 = st2;
        if (rst) begin
            m_s = 0;
            m_live = 1'b1;
        end else if (m_s == 0) begin
            if (st) m_s = 1;
            m_live = 1'b1;
        end else if (STALL_EN && sl) begin
            m_live = 1'b0;
        end else begin
            m_live = 1'b1;
            m_s = (m_s == LAST + 1) ? 0 : m_s + 1;
        end
        cyc++;
    endtask

    task automatic clear_counts();
        n_wr = 0; n_done = 0; done_cyc = -1;
        n_relu2 = 0; n_accu2 = 0; n_wr2 = 0; done2_cyc = -1;
    endtask

    function automatic bit poke_start(input int c);
        return (m_s > 0) && (m_s < LAST) && ((c == 500) || ($urandom_range(0, 199) == 0));
    endfunction

    function automatic bit poke_stall(input int c);
        if (STALL_EN) return (c >= 200) && (c < 210);
        return ($urandom_range(0, 3) == 0);
    endfunction

    initial begin
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Full layer with busy-time start pokes and stall activity.
        clear_counts();
        cyc = 0;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int c = 1; c < LAST + NST + 20; c++) step(1'b0, poke_start(c), poke_stall(c), 1'b0);
        check("done_cyc", done_cyc, LAST + 1 + NST);
        check("done_cnt", n_done, 1);
        check("wr_total", n_wr, NPASS * ON * ON);
        check("d1_relu", n_relu2, ON * ON);
        check("d1_accu", n_accu2, 0);
        check("d1_wr", n_wr2, ON * ON);
        check("d1_done", done2_cyc, PASS_LEN + 1);

        // Abort mid-layer by reset, then a start coincident with reset must be ignored.
        clear_counts();
        cyc = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c < 3010; c++) step(c == 3000, poke_start(c), 1'b0, 1'b0);
        check("abort_done", n_done, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_busy", busy, 1'b0);

        // Fresh layer after the abort.
        clear_counts();
        cyc = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c < LAST + 20; c++) step(1'b0, poke_start(c), STALL_EN ? 1'b0 : poke_stall(c), 1'b0);
        check("rerun_done_cyc", done_cyc, LAST + 1);
        check("rerun_wr_total", n_wr, NPASS * ON * ON);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
